xeng_acc_reader: RTL and testbench
==================================

XENG_ACC_READER -- requirements
Module: xeng_acc_reader

Interface
REQ-001 SHALL have parameter SERIAL_ACC_LEN_BITS, default 7, serial accumulation length (2^n) of the upstream taps.
REQ-002 SHALL have parameter P_FACTOR_BITS, default 2, parallel sample factor (2^n) of the upstream taps.
REQ-003 SHALL have parameter BITWIDTH, default 4, real/imag bitwidth of upstream samples.
REQ-004 SHALL have parameter N_ANTS, default 32, number of dual-pol antennas; N_BLS = N_ANTS*(N_ANTS+1)/2 baselines per dump (528 at default).
REQ-005 SHALL have parameter FIFO_DEPTH_BITS, default 6, output buffer depth 2^n words.
REQ-006 SHALL define ACC_WIDTH = 8*((2*BITWIDTH+1)+P_FACTOR_BITS+SERIAL_ACC_LEN_BITS) (144 at defaults), and BL_BITS = clog2(N_BLS).
REQ-007 clk  input  1  sole clock, all logic rising-edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 sync_in  input  1  sync pulse from the end of the tap chain.
REQ-010 acc_in  input  ACC_WIDTH  accumulation word from last tap.
REQ-011 valid_in  input  1  acc_in qualifier.
REQ-012 dout  output  ACC_WIDTH  buffered accumulation word.
REQ-013 dout_bl  output  BL_BITS  baseline index of dout.
REQ-014 dout_last  output  1  dout is baseline N_BLS-1.
REQ-015 dout_valid  output  1  dout/dout_bl/dout_last valid.
REQ-016 dout_ready  input  1  downstream accepts word.
REQ-017 overflow  output  1  sticky word-dropped flag.
REQ-018 drop_cnt  output  16  dropped-word count (see Configuration).

Function
REQ-019 SHALL implement two states: IDLE (after reset, before first sync_in) and RUN.
REQ-020 In IDLE, valid_in words SHALL be discarded without counting or flagging; sync_in SHALL move to RUN.
REQ-021 In RUN, sync_in SHALL reset baseline counter to 0; state stays RUN.
REQ-022 Each valid_in in RUN SHALL be tagged with current baseline index (index 0 if sync_in same cycle), then counter increments, wrapping N_BLS-1 -> 0.
REQ-023 dout_last SHALL equal (tag == N_BLS-1).
REQ-024 Tagged word SHALL be pushed into FIFO of 2^FIFO_DEPTH_BITS entries (word + tag + last).
REQ-025 FIFO SHALL be first-word-fall-through: word pushed on cycle N visible on dout with dout_valid=1 at cycle N+1 if FIFO was empty.
REQ-026 Pop occurs when dout_valid && dout_ready; dout SHALL hold stable while dout_valid && !dout_ready.
REQ-027 When full, a push with simultaneous pop SHALL be accepted; a push without pop SHALL be dropped.
REQ-028 Dropped word SHALL still advance the baseline counter (alignment preserved), and SHALL set overflow.
REQ-029 overflow SHALL clear only on rst or on sync_in in RUN (sync clears flag, same-cycle drop re-sets it).
REQ-030 Empty FIFO with dout_ready=1 SHALL not pop; dout_valid=0.

Reset
REQ-031 rst SHALL asynchronously force: state IDLE, baseline counter 0, FIFO empty, dout_valid 0, dout 0, dout_bl 0, dout_last 0, overflow 0, drop_cnt 0.
REQ-032 rst asserted mid-dump SHALL discard all buffered words; after release, data is ignored until next sync_in.

Configuration
REQ-033 Macro XENG_ACC_READER_DROP_CNT_EN: when defined, drop_cnt SHALL count dropped words, saturating at 0xFFFF, cleared by rst and by sync_in in RUN (same-cycle drop counts as 1).
REQ-034 When XENG_ACC_READER_DROP_CNT_EN undefined, drop_cnt SHALL be constant 0 and no counter logic instantiated; all other behaviour identical.

Verification
REQ-035 valid_in pulses with no prior sync_in -> dout_valid stays 0, overflow 0.
REQ-036 sync_in, then 528 consecutive valid_in, dout_ready=1 -> 528 outputs, dout_bl 0..527 in order, dout_last only on 527, each 1 cycle after input.
REQ-037 sync_in with valid_in same cycle, acc_in=0x1 -> that word emerges with dout_bl=0; next word dout_bl=1.
REQ-038 dout_ready=0, 70 valid words after sync (depth 64) -> 64 buffered, overflow=1, drop_cnt=6 (macro on) / 0 (macro off); then drain -> bl 0..63; next input tagged 70.
REQ-039 FIFO full, push with pop same cycle -> no drop, overflow stays 0, count stays 64.
REQ-040 rst asserted with 10 words buffered -> dout_valid 0 immediately (asynchronously); subsequent valid_in ignored until sync_in.

Source files
------------

// File: rtl/xeng_acc_reader.sv
// ---------------------------------------------------------------------------
// xeng_acc_reader
//
// Collects accumulation words coming off the end of the X-engine tap chain,
// tags each one with its baseline index and buffers it in a first-word-fall-
// through FIFO for a ready/valid consumer.
//
// The baseline counter only starts once the first sync_in has been seen.
// Every later sync_in re-aligns it to baseline 0.
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   sync_in     in   sync pulse from end of tap chain
//   acc_in      in   accumulation word (ACC_WIDTH)
//   valid_in    in   acc_in qualifier
//   dout        out  buffered accumulation word (registered)
//   dout_bl     out  baseline index of dout (BL_BITS)
//   dout_last   out  dout is baseline N_BLS-1
//   dout_valid  out  dout/dout_bl/dout_last valid
//   dout_ready  in   downstream accepts word
//   overflow    out  sticky word-dropped flag, cleared by rst or sync in RUN
//   drop_cnt    out  16-bit saturating dropped-word count
//
// Optional feature
//   XENG_ACC_READER_DROP_CNT_EN : when defined, drop_cnt counts dropped words.
//                                 Otherwise it is tied to zero and no counter
//                                 is built.
// ---------------------------------------------------------------------------
module xeng_acc_reader #(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int P_FACTOR_BITS       = 2,
    parameter int BITWIDTH            = 4,
    parameter int N_ANTS              = 32,
    parameter int FIFO_DEPTH_BITS     = 6,
    localparam int ACC_WIDTH = 8 * ((2 * BITWIDTH + 1) + P_FACTOR_BITS + SERIAL_ACC_LEN_BITS),
    localparam int N_BLS     = N_ANTS * (N_ANTS + 1) / 2,
    localparam int BL_BITS   = (N_BLS > 1) ? $clog2(N_BLS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync_in,
    input  logic [ACC_WIDTH-1:0] acc_in,
    input  logic                 valid_in,
    output logic [ACC_WIDTH-1:0] dout,
    output logic [BL_BITS-1:0]   dout_bl,
    output logic                 dout_last,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 overflow,
    output logic [15:0]          drop_cnt
);

    localparam int PTR_W = FIFO_DEPTH_BITS;
    localparam int CNT_W = FIFO_DEPTH_BITS + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    // A FIFO entry holds {last, baseline tag, word}.
    localparam int ENT_W = ACC_WIDTH + BL_BITS + 1;

    localparam logic [BL_BITS-1:0] LAST_BL = BL_BITS'(N_BLS - 1);
    localparam logic [BL_BITS-1:0] BL_ONE  = BL_BITS'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [BL_BITS-1:0]   bl_cnt_q, bl_cnt_d;
    logic                 overflow_q, overflow_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [ENT_W-1:0]     head_q, head_d;

    logic [ENT_W-1:0]     mem_q [DEPTH];

    logic                 run_s;
    logic                 sync_run_s;
    logic                 push_req_s;
    logic                 full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;
    logic [BL_BITS-1:0]   tag_s;
    logic [ENT_W-1:0]     wr_ent_s;

    // Handshake decode: who pushes, who pops, and what gets dropped.
    always_comb begin
        run_s      = (state_q == ST_RUN);
        sync_run_s = run_s && sync_in;
        push_req_s = run_s && valid_in;
        full_s     = (count_q == CNT_FULL);
        pop_s      = dout_valid_q && dout_ready;
        // A full FIFO still accepts a word when a pop frees a slot on the same edge.
        push_s     = push_req_s && (!full_s || pop_s);
        drop_s     = push_req_s && full_s && !pop_s;
        if (sync_in) begin
            tag_s = {BL_BITS{1'b0}};
        end else begin
            tag_s = bl_cnt_q;
        end
        wr_ent_s = {(tag_s == LAST_BL), tag_s, acc_in};
    end

    // Next state for the IDLE/RUN controller and the baseline counter.
    always_comb begin
        state_d  = state_q;
        bl_cnt_d = bl_cnt_q;
        case (state_q)
            ST_IDLE: begin
                bl_cnt_d = {BL_BITS{1'b0}};
                if (sync_in) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                // Dropped words advance the counter too, so tags stay aligned.
                if (valid_in) begin
                    if (tag_s == LAST_BL) begin
                        bl_cnt_d = {BL_BITS{1'b0}};
                    end else begin
                        bl_cnt_d = tag_s + BL_ONE;
                    end
                end else if (sync_in) begin
                    bl_cnt_d = {BL_BITS{1'b0}};
                end else begin
                    bl_cnt_d = bl_cnt_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bl_cnt_d = {BL_BITS{1'b0}};
            end
        endcase
    end

    // Sticky overflow: sync in RUN clears it, a drop on the same cycle re-sets it.
    always_comb begin
        overflow_d = overflow_q;
        if (sync_run_s) begin
            overflow_d = drop_s;
        end else begin
            overflow_d = overflow_q | drop_s;
        end
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Registered head of FIFO. The entry that will sit at rd_ptr after this
    // edge is either the word being written there right now (empty FIFO, or
    // last word popping) or what is already stored in memory.
    always_comb begin
        head_d       = {ENT_W{1'b0}};
        dout_valid_d = (count_d != {CNT_W{1'b0}});
        if (!dout_valid_d) begin
            head_d = {ENT_W{1'b0}};
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wr_ent_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Controller, counter, FIFO bookkeeping and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bl_cnt_q     <= {BL_BITS{1'b0}};
            overflow_q   <= 1'b0;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            dout_valid_q <= 1'b0;
            head_q       <= {ENT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            bl_cnt_q     <= bl_cnt_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_valid_q <= dout_valid_d;
            head_q       <= head_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_ent_s;
        end
    end

    assign dout       = head_q[ACC_WIDTH-1:0];
    assign dout_bl    = head_q[ACC_WIDTH +: BL_BITS];
    assign dout_last  = head_q[ENT_W-1];
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;

`ifdef XENG_ACC_READER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] drop_base_s;

    // Saturating drop counter; sync in RUN restarts it, same-cycle drop counts.
    always_comb begin
        drop_base_s = drop_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (sync_run_s) begin
            drop_base_s = 16'h0000;
        end else begin
            drop_base_s = drop_cnt_q;
        end
        if (drop_s && (drop_base_s != 16'hFFFF)) begin
            drop_cnt_d = drop_base_s + 16'h0001;
        end else begin
            drop_cnt_d = drop_base_s;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_xeng_acc_reader.sv
// Directed self-checking bench for xeng_acc_reader at default parameters.
module tb_xeng_acc_reader;

    localparam int ACC_W = 144;
    localparam int BL_W  = 10;
`ifdef XENG_ACC_READER_DROP_CNT_EN
    localparam logic [15:0] EXP_DROPS = 16'd6;
`else
    localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

    logic             clk;
    logic             rst;
    logic             sync_in;
    logic [ACC_W-1:0] acc_in;
    logic             valid_in;
    logic [ACC_W-1:0] dout;
    logic [BL_W-1:0]  dout_bl;
    logic             dout_last;
    logic             dout_valid;
    logic             dout_ready;
    logic             overflow;
    logic [15:0]      drop_cnt;

    int vectors;
    int miscompares;

    xeng_acc_reader dut (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .acc_in     (acc_in),
        .valid_in   (valid_in),
        .dout       (dout),
        .dout_bl    (dout_bl),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ACC_W-1:0] word(input int i);
        logic [ACC_W-1:0] w;
        w = {8'h5A, 104'h0, 32'(i)};
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        sync_in     = 1'b0;
        acc_in      = '0;
        valid_in    = 1'b0;
        dout_ready  = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_valid", 160'(dout_valid), 160'(1'b0));
        chk("rst_dout", 160'(dout), 160'(0));
        chk("rst_bl", 160'(dout_bl), 160'(0));
        chk("rst_last", 160'(dout_last), 160'(1'b0));
        chk("rst_ovf", 160'(overflow), 160'(1'b0));
        chk("rst_drop", 160'(drop_cnt), 160'(0));
        rst = 1'b0;
        tick();

        // Data before any sync is ignored
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            acc_in = word(900 + i);
            tick();
            chk("idle_valid", 160'(dout_valid), 160'(1'b0));
            chk("idle_ovf", 160'(overflow), 160'(1'b0));
        end
        valid_in = 1'b0;

        // Full dump with ready held high: one cycle latency, bl 0..527
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        chk("sync_only_valid", 160'(dout_valid), 160'(1'b0));
        for (int i = 0; i < 528; i++) begin
            valid_in = 1'b1;
            acc_in   = word(i);
            tick();
            chk("dump_valid", 160'(dout_valid), 160'(1'b1));
            chk("dump_bl", 160'(dout_bl), 160'(i));
            chk("dump_dout", 160'(dout), 160'(word(i)));
            chk("dump_last", 160'(dout_last), 160'(i == 527));
        end
        valid_in = 1'b0;
        tick();
        chk("dump_empty", 160'(dout_valid), 160'(1'b0));

        // sync with valid on the same cycle tags that word 0
        sync_in  = 1'b1;
        valid_in = 1'b1;
        acc_in   = 144'h1;
        tick();
        chk("samecyc_dout", 160'(dout), 160'(1));
        chk("samecyc_bl", 160'(dout_bl), 160'(0));
        sync_in = 1'b0;
        acc_in  = 144'h2;
        tick();
        chk("samecyc_next_dout", 160'(dout), 160'(2));
        chk("samecyc_next_bl", 160'(dout_bl), 160'(1));
        valid_in = 1'b0;
        tick();
        chk("samecyc_empty", 160'(dout_valid), 160'(1'b0));

        // Overflow: 70 words into a 64-deep FIFO with no consumer
        dout_ready = 1'b0;
        sync_in    = 1'b1;
        tick();
        sync_in = 1'b0;
        for (int i = 0; i < 70; i++) begin
            valid_in = 1'b1;
            acc_in   = word(1000 + i);
            tick();
            if (i == 63) chk("ovf_at_64", 160'(overflow), 160'(1'b0));
            if (i == 64) chk("ovf_at_65", 160'(overflow), 160'(1'b1));
        end
        valid_in = 1'b0;
        tick();
        chk("ovf_hold_valid", 160'(dout_valid), 160'(1'b1));
        chk("ovf_hold_dout", 160'(dout), 160'(word(1000)));
        chk("ovf_hold_bl", 160'(dout_bl), 160'(0));
        chk("ovf_flag", 160'(overflow), 160'(1'b1));
        chk("ovf_drops", 160'(drop_cnt), 160'(EXP_DROPS));
        dout_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            chk("drain_bl", 160'(dout_bl), 160'(k));
            chk("drain_dout", 160'(dout), 160'(word(1000 + k)));
            tick();
        end
        chk("drain_empty", 160'(dout_valid), 160'(1'b0));
        valid_in = 1'b1;
        acc_in   = word(2000);
        tick();
        valid_in = 1'b0;
        chk("post_drop_bl", 160'(dout_bl), 160'(70));
        chk("post_drop_valid", 160'(dout_valid), 160'(1'b1));
        chk("ovf_sticky", 160'(overflow), 160'(1'b1));
        tick();
        chk("post_drop_empty", 160'(dout_valid), 160'(1'b0));

        // Full FIFO with simultaneous push and pop: nothing dropped
        dout_ready = 1'b0;
        sync_in    = 1'b1;
        tick();
        sync_in = 1'b0;
        chk("sync_clr_ovf", 160'(overflow), 160'(1'b0));
        chk("sync_clr_drop", 160'(drop_cnt), 160'(0));
        for (int i = 0; i < 64; i++) begin
            valid_in = 1'b1;
            acc_in   = word(3000 + i);
            tick();
        end
        chk("full_ovf", 160'(overflow), 160'(1'b0));
        dout_ready = 1'b1;
        acc_in     = word(3064);
        tick();
        valid_in = 1'b0;
        chk("pushpop_ovf", 160'(overflow), 160'(1'b0));
        chk("pushpop_drop", 160'(drop_cnt), 160'(0));
        chk("pushpop_bl", 160'(dout_bl), 160'(1));
        for (int k = 1; k <= 64; k++) begin
            chk("pushpop_drain_bl", 160'(dout_bl), 160'(k));
            chk("pushpop_drain_dout", 160'(dout), 160'(word(3000 + k)));
            tick();
        end
        chk("pushpop_empty", 160'(dout_valid), 160'(1'b0));

        // Asynchronous reset with 10 words buffered
        dout_ready = 1'b0;
        sync_in    = 1'b1;
        tick();
        sync_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid_in = 1'b1;
            acc_in   = word(4000 + i);
            tick();
        end
        valid_in = 1'b0;
        chk("pre_rst_valid", 160'(dout_valid), 160'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 160'(dout_valid), 160'(1'b0));
        chk("async_rst_dout", 160'(dout), 160'(0));
        chk("async_rst_bl", 160'(dout_bl), 160'(0));
        tick();
        rst        = 1'b0;
        dout_ready = 1'b1;
        valid_in   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            acc_in = word(5000 + i);
            tick();
            chk("post_rst_ignored", 160'(dout_valid), 160'(1'b0));
        end
        valid_in = 1'b0;
        sync_in  = 1'b1;
        tick();
        sync_in  = 1'b0;
        valid_in = 1'b1;
        acc_in   = word(6000);
        tick();
        valid_in = 1'b0;
        chk("resync_valid", 160'(dout_valid), 160'(1'b1));
        chk("resync_bl", 160'(dout_bl), 160'(0));
        chk("resync_dout", 160'(dout), 160'(word(6000)));
        tick();
        chk("resync_empty", 160'(dout_valid), 160'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
